// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side and control-side bundle of the next-PC generator.
// master is the generator, slave is the hazard/execute/imem environment.
interface pc_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  stall;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_PC;
    logic                  fetch_ready;
    logic [DATA_WIDTH-1:0] PC;
    logic                  PC_valid;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;
    logic                  upd_en;
    logic [DATA_WIDTH-1:0] upd_PC;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] upd_target;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_PC,
        input  fetch_ready,
        input  upd_en,
        input  upd_PC,
        input  upd_taken,
        input  upd_target,
        output PC,
        output PC_valid,
        output pred_taken,
        output pred_target
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_PC,
        output fetch_ready,
        output upd_en,
        output upd_PC,
        output upd_taken,
        output upd_target,
        input  PC,
        input  PC_valid,
        input  pred_taken,
        input  pred_target
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with stall/redirect handling and an optional
// direct-mapped BTB, enabled by defining PC_GEN_BTB_EN.
module pc_gen #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    BTB_ENTRIES = 16
) (
    input logic      clk,
    input logic      rst,
    pc_gen_if.master bus
);
    // PC is held as a word address; the two low bits are always zero.
    localparam int WW = DATA_WIDTH - 2;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [WW-1:0] pc_q;
    logic [WW-1:0] pc_d;
    logic [WW-1:0] pc_inc;
    logic [WW-1:0] pred_w;
    logic          hit;
    logic          advance;

    assign pc_inc  = pc_q + WW'(1);
    assign advance = bus.fetch_ready && !bus.stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.redirect) begin
            state_d = RUN;
            pc_d    = bus.redirect_PC[DATA_WIDTH-1:2];
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN, HOLD: begin
                    if (advance) begin
                        state_d = RUN;
                        pc_d    = pred_w;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC[DATA_WIDTH-1:2];
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.PC          = {pc_q, 2'b00};
    assign bus.PC_valid    = (state_q != BOOT);
    assign bus.pred_taken  = hit;
    assign bus.pred_target = {pred_w, 2'b00};

`ifdef PC_GEN_BTB_EN
    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = WW - IW;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [BTB_ENTRIES-1:0] valid_d;
    logic [TW-1:0]          tag_q [BTB_ENTRIES];
    logic [WW-1:0]          tgt_q [BTB_ENTRIES];
    logic [WW-1:0]          up_w;
    logic [IW-1:0]          up_idx;
    logic [TW-1:0]          up_tag;
    logic [IW-1:0]          lk_idx;
    logic [TW-1:0]          lk_tag;
    logic                   unused_low;

    assign up_w   = bus.upd_PC[DATA_WIDTH-1:2];
    assign up_idx = up_w[IW-1:0];
    assign up_tag = up_w[WW-1:IW];
    assign lk_idx = pc_q[IW-1:0];
    assign lk_tag = pc_q[WW-1:IW];

    // Lookup reads registered contents, so a same-cycle update is not seen.
    assign hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_w = hit ? tgt_q[lk_idx] : pc_inc;

    always_comb begin
        valid_d = valid_q;
        if (bus.upd_en) begin
            if (bus.upd_taken) begin
                valid_d[up_idx] = 1'b1;
            end else if (tag_q[up_idx] == up_tag) begin
                valid_d[up_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.upd_en && bus.upd_taken) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= bus.upd_target[DATA_WIDTH-1:2];
        end
    end

    assign unused_low = ^{bus.upd_PC[1:0], bus.upd_target[1:0]};
`else
    localparam int unused_entries = BTB_ENTRIES;
    logic unused_upd;

    assign hit        = 1'b0;
    assign pred_w     = pc_inc;
    assign unused_upd = ^{bus.upd_en, bus.upd_PC,
                          bus.upd_taken, bus.upd_target};
`endif

    logic unused_rd;
    assign unused_rd = ^bus.redirect_PC[1:0];
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: vector table plus randomized stall/handshake run for pc_gen.
// BTB expectations follow PC_GEN_BTB_EN.
module tb_pc_gen;
    localparam int DW = 32;
`ifdef PC_GEN_BTB_EN
    localparam bit B = 1'b1;
`else
    localparam bit B = 1'b0;
`endif

    typedef struct {
        logic          rst;
        logic          st;
        logic          rd;
        logic [DW-1:0] rpc;
        logic          fr;
        logic          ue;
        logic [DW-1:0] upc;
        logic          ut;
        logic [DW-1:0] utg;
        logic [DW-1:0] epc;
        logic          ev;
        logic          ek;
        logic [DW-1:0] etg;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    vec_t vecs[$];
    vec_t exp_q[$];

    pc_gen_if #(.DATA_WIDTH(DW)) bus ();

    pc_gen #(
        .DATA_WIDTH (DW),
        .RESET_PC   (32'h100),
        .BTB_ENTRIES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rs, input logic s, input logic r,
        input logic [DW-1:0] rp, input logic f,
        input logic ue, input logic [DW-1:0] up,
        input logic ut, input logic [DW-1:0] ug,
        input logic [DW-1:0] ep, input logic ev,
        input logic ek, input logic [DW-1:0] eg);
        vec_t v;
        v.rst = rs; v.st = s; v.rd = r; v.rpc = rp; v.fr = f;
        v.ue = ue; v.upc = up; v.ut = ut; v.utg = ug;
        v.epc = ep; v.ev = ev; v.ek = ek; v.etg = eg;
        return v;
    endfunction

    // Plain cycle: no redirect, no update.
    function automatic vec_t go(
        input logic s, input logic f,
        input logic [DW-1:0] ep, input logic ek,
        input logic [DW-1:0] eg);
        return mk(0, s, 0, 0, f, 0, 0, 0, 0, ep, 1, ek, eg);
    endfunction

    task automatic apply(input vec_t t, input string nm);
        vec_t e;
        rst             = t.rst;
        bus.stall       = t.st;
        bus.redirect    = t.rd;
        bus.redirect_PC = t.rpc;
        bus.fetch_ready = t.fr;
        bus.upd_en      = t.ue;
        bus.upd_PC      = t.upc;
        bus.upd_taken   = t.ut;
        bus.upd_target  = t.utg;
        exp_q.push_back(t);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (bus.PC !== e.epc || bus.PC_valid !== e.ev ||
            bus.pred_taken !== e.ek || bus.pred_target !== e.etg) begin
            n_miss++;
            $display("FAIL %s: got PC=%h v=%b pt=%b tgt=%h want PC=%h v=%b pt=%b tgt=%h",
                     nm, bus.PC, bus.PC_valid, bus.pred_taken, bus.pred_target,
                     e.epc, e.ev, e.ek, e.etg);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] m;
        logic          s;
        logic          f;
        n_vec  = 0;
        n_miss = 0;

        vecs.push_back(mk(1,0,0,0,1, 0,0,0,0, 32'h100,0,0,32'h104));
        vecs.push_back(mk(1,0,0,0,1, 0,0,0,0, 32'h100,0,0,32'h104));
        vecs.push_back(go(0,1, 32'h100,0,32'h104));
        vecs.push_back(go(0,1, 32'h104,0,32'h108));
        vecs.push_back(go(0,1, 32'h108,0,32'h10C));
        vecs.push_back(mk(0,0,1,32'h20,1, 0,0,0,0, 32'h20,1,0,32'h24));
        vecs.push_back(go(1,1, 32'h20,0,32'h24));
        vecs.push_back(go(1,1, 32'h20,0,32'h24));
        vecs.push_back(go(1,1, 32'h20,0,32'h24));
        vecs.push_back(go(0,0, 32'h20,0,32'h24));
        vecs.push_back(go(0,0, 32'h20,0,32'h24));
        vecs.push_back(go(0,1, 32'h24,0,32'h28));
        vecs.push_back(mk(0,1,1,32'h403,0, 0,0,0,0, 32'h400,1,0,32'h404));
        vecs.push_back(go(0,1, 32'h404,0,32'h408));
        vecs.push_back(mk(0,0,1,32'hFFFFFFFF,1, 0,0,0,0, 32'hFFFFFFFC,1,0,32'h0));
        vecs.push_back(go(0,1, 32'h0,0,32'h4));
        vecs.push_back(go(0,1, 32'h4,0,32'h8));
        vecs.push_back(mk(1,0,1,32'h500,1, 1,32'h40,1,32'h80, 32'h100,0,0,32'h104));
        vecs.push_back(go(0,1, 32'h100,0,32'h104));
        vecs.push_back(mk(0,0,1,32'h40,1, 0,0,0,0, 32'h40,1,0,32'h44));
        vecs.push_back(mk(0,0,1,32'h30,1, 1,32'h40,1,32'h80, 32'h30,1,0,32'h34));
        vecs.push_back(go(0,1, 32'h34,0,32'h38));
        vecs.push_back(go(0,1, 32'h38,0,32'h3C));
        vecs.push_back(go(0,1, 32'h3C,0,32'h40));
        vecs.push_back(go(0,1, 32'h40,B,B ? 32'h80 : 32'h44));
        vecs.push_back(go(0,1, B ? 32'h80 : 32'h44,0,B ? 32'h84 : 32'h48));
        vecs.push_back(mk(0,0,1,32'h40,1, 1,32'h40,0,0, 32'h40,1,0,32'h44));
        vecs.push_back(go(0,1, 32'h44,0,32'h48));
        vecs.push_back(mk(0,0,1,32'h40,1, 1,32'h40,1,32'h83,
                          32'h40,1,B,B ? 32'h80 : 32'h44));
        vecs.push_back(mk(0,0,0,0,1, 1,32'h50,1,32'h90,
                          B ? 32'h80 : 32'h44,1,0,B ? 32'h84 : 32'h48));
        vecs.push_back(mk(0,0,1,32'h40,1, 0,0,0,0, 32'h40,1,0,32'h44));
        vecs.push_back(mk(0,0,1,32'h50,1, 0,0,0,0,
                          32'h50,1,B,B ? 32'h90 : 32'h54));
        vecs.push_back(mk(0,0,1,32'h50,1, 1,32'h40,0,0,
                          32'h50,1,B,B ? 32'h90 : 32'h54));
        vecs.push_back(mk(0,1,0,0,1, 1,32'h50,0,0, 32'h50,1,0,32'h54));
        vecs.push_back(mk(0,0,1,32'h1000,1, 0,0,0,0, 32'h1000,1,0,32'h1004));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Random stall/handshake pattern against a sequential-PC model.
        m = 32'h1000;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
            if (f && !s) m = m + 32'h4;
            apply(go(s, f, m, 0, m + 32'h4), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised next-PC generator for the pipelined RV32 core, replacing the single-cycle PC/increment/branch-mux front end. Holds the fetch PC, advances it by 4 under a fetch handshake, honours pipeline stalls and execute-stage redirects, and optionally predicts taken branches through a small direct-mapped branch target buffer (BTB). Sits between the hazard unit / execute stage and the instruction memory.

## Interface
- DATA_WIDTH, 32, PC and target width (≥ 8).
- RESET_PC, 0, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥ 2 (ignored without BTB_EN).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- stall  input  1  hazard-unit stall; hold PC.
- redirect  input  1  execute-stage redirect (taken branch, jump, or mispredict correction).
- redirect_PC  input  DATA_WIDTH  redirect target.
- fetch_ready  input  1  instruction memory accepts current PC.
- PC  output  DATA_WIDTH  current fetch PC (registered).
- PC_valid  output  1  PC is a real fetch request.
- pred_taken  output  1  BTB predicts taken for PC (combinational from PC; 0 without BTB_EN).
- pred_target  output  DATA_WIDTH  predicted target (PC+4 when not predicted taken).
- upd_en  input  1  BTB update strobe from execute stage.
- upd_PC  input  DATA_WIDTH  PC of resolved branch.
- upd_taken  input  1  resolved direction.
- upd_target  input  DATA_WIDTH  resolved target.

## Operation
- States: BOOT, RUN, HOLD.
- BOOT: entered on rst; PC = RESET_PC, PC_valid = 0. Next cycle → RUN unconditionally (unless rst).
- RUN: PC_valid = 1. Advance when fetch_ready && !stall: PC ← pred_target. Otherwise → HOLD, PC unchanged.
- HOLD: PC_valid = 1, PC unchanged; → RUN on the cycle fetch_ready && !stall, advancing as in RUN.
- redirect in any state (except rst asserted): PC ← {redirect_PC[DATA_WIDTH-1:2], 2'b00}, state → RUN; overrides stall, fetch_ready and prediction.
- Priority: rst > redirect > (stall or !fetch_ready) > advance.
- Arithmetic: PC+4 is modulo 2^DATA_WIDTH; max aligned PC + 4 wraps to 0. PC[1:0] always 0; upd_target and redirect_PC low two bits discarded.
- BTB (BTB_EN only): entry = valid, tag, target. index = PC[2 +: log2(BTB_ENTRIES)], tag = remaining upper PC bits. Hit = valid && tag match → pred_taken = 1, pred_target = entry target.
- BTB update on upd_en: upd_taken = 1 writes valid=1, tag, target at upd_PC index (overwrites any alias); upd_taken = 0 clears valid only if tag matches.
- Same-cycle lookup and update of one index: lookup returns pre-update contents.
- rst clears all BTB valid bits.

## Timing
- Reset values: PC = RESET_PC, PC_valid = 0, state BOOT, pred_taken = 0, pred_target = RESET_PC+4.
- First valid fetch: cycle after rst deasserts.
- Redirect latency: 1 cycle (redirect at edge N → PC = redirect_PC after edge N+1).
- BTB update visible to lookup 1 cycle after upd_en.
- rst mid-operation: on next edge all state returns to reset values regardless of redirect/upd_en.
- Throughput: one PC per cycle while fetch_ready && !stall.

## Configuration
- PC_GEN_BTB_EN defined: BTB instantiated; prediction and update as above.
- Undefined: no BTB storage; pred_taken tied 0, pred_target = PC+4; upd_* ports present but ignored.

## Test plan
- Reset RESET_PC=0x100: rst 2 cycles, release → PC=0x100 valid=0 one cycle, then 0x100 valid=1, 0x104, 0x108 on consecutive cycles.
- Stall/handshake: stall for 3 cycles at PC 0x20, then fetch_ready low 2 cycles → PC holds 0x20 for 5 cycles, PC_valid stays 1, then 0x24.
- Redirect vs stall: stall=1, redirect=1, redirect_PC=0x403 same cycle → next PC=0x400; wrap: PC=0xFFFFFFFC advances to 0x0.
- BTB (macro on): upd_en, upd_PC=0x40, taken, target=0x80 → next pass at PC 0x40 shows pred_taken=1, next PC 0x80; upd not-taken at 0x40 → later prediction 0x44.
- BTB alias/simultaneous: BTB_ENTRIES=4, entries at 0x40 then 0x50 (same index) → 0x40 no longer hits; update and lookup same index same cycle → old result that cycle.
- Macro off: same update sequence → pred_taken always 0, PC strictly sequential.
